// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage RAM access controller.
package mem_access_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic READ_ENABLE  = 1'b1;
   localparam logic WRITE_ENABLE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC0 = 2'b01,
      ST_ACC1 = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Access width in bytes; the illegal encoding is treated as a word here
   // and rejected separately.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // True when the access spills over into the next aligned word.
   function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] offset);
      return ({1'b0, offset} + size_bytes(size)) > 3'd4;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Byte-lane steering for big-endian RAM words: store data/lane placement
// across up to two words, and load extraction plus extension.
module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sgn,
   input  logic [31:0] wdata,
   input  logic [31:0] rd0,
   input  logic [31:0] rd1,
   output logic [31:0] wdata_hi,
   output logic [31:0] wdata_lo,
   output logic [3:0]  lanes_hi,
   output logic [3:0]  lanes_lo,
   output logic        split,
   output logic [31:0] rdata
);

   logic [2:0]  n;
   logic [5:0]  sh_n;
   logic [5:0]  sh_o;
   logic [31:0] wshift;
   logic [63:0] v;
   logic [63:0] cat;
   logic [7:0]  ones;
   logic [7:0]  m;
   logic [31:0] r;

   // Left-justify the store data, slide it right by the byte offset over a
   // two-word window; loads do the inverse and then extend.
   always_comb begin
      n        = size_bytes(size);
      split    = crosses_word(size, offset);
      sh_n     = {3'(3'd4 - n), 3'b000};
      sh_o     = {1'b0, offset, 3'b000};
      wshift   = wdata << sh_n;
      v        = {wshift, 32'h0} >> sh_o;
      case (n)
         3'd1:    ones = 8'h80;
         3'd2:    ones = 8'hC0;
         default: ones = 8'hF0;
      endcase
      m        = ones >> offset;
      wdata_hi = v[63:32];
      wdata_lo = v[31:0];
      lanes_hi = m[7:4];
      lanes_lo = m[3:0];
      cat      = {rd0, rd1} << sh_o;
      r        = cat[63:32] >> sh_n;
      case (size)
         SZ_BYTE: rdata = {{24{sgn & r[7]}}, r[7:0]};
         SZ_HALF: rdata = {{16{sgn & r[15]}}, r[15:0]};
         default: rdata = r;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the instruction/data RAM port: one request at a
// time, unaligned accesses optionally split into two aligned word cycles.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_ce,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_read_addr,
   input  logic [31:0] mem_read_data,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_write
);

   state_t      state, state_nxt;
   req_t        req_q;
   logic        err_q;
   logic [31:0] rd0, rd1;
   logic        accept, req_err;
   logic [31:0] base, acc_addr;
   logic [31:0] wdata_hi, wdata_lo, ld_data;
   logic [3:0]  lanes_hi, lanes_lo;
   logic        split;

   assign accept  = req_valid & req_ready;
   assign req_err = (req_size == SZ_ILL) | (!SPLIT_EN & crosses_word(req_size, req_addr[1:0]));

   mem_lane_align u_align (
      .size     (req_q.size),
      .offset   (req_q.addr[1:0]),
      .sgn      (req_q.sgn),
      .wdata    (req_q.wdata),
      .rd0      (rd0),
      .rd1      (rd1),
      .wdata_hi (wdata_hi),
      .wdata_lo (wdata_lo),
      .lanes_hi (lanes_hi),
      .lanes_lo (lanes_lo),
      .split    (split),
      .rdata    (ld_data)
   );

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Request capture at accept, RAM read words captured after each access cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         err_q <= 1'b0;
         rd0   <= '0;
         rd1   <= '0;
      end else if (accept) begin
         req_q <= '{we: req_we, size: req_size, sgn: req_signed, addr: req_addr, wdata: req_wdata};
         err_q <= req_err;
         rd0   <= '0;
         rd1   <= '0;
      end else if (state == ST_ACC0) begin
         rd0   <= mem_read_data;
      end else if (state == ST_ACC1) begin
         rd1   <= mem_read_data;
      end
   end

   // Next state plus all outputs, decoded from the current state only.
   always_comb begin
      state_nxt      = state;
      req_ready      = (state == ST_IDLE);
      mem_ce         = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      mem_read_addr  = '0;
      mem_write_addr = '0;
      mem_write_data = '0;
      mem_write      = '0;
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      resp_rdata     = '0;
      base           = {req_q.addr[31:2], 2'b00};
      acc_addr       = (state == ST_ACC1) ? base + 32'd4 : base;

      case (state)
         ST_IDLE: if (accept) state_nxt = req_err ? ST_DONE : ST_ACC0;
         ST_ACC0: state_nxt = split ? ST_ACC1 : ST_DONE;
         ST_ACC1: state_nxt = ST_DONE;
         default: state_nxt = ST_IDLE;
      endcase

      if (state == ST_ACC0 || state == ST_ACC1) begin
         mem_ce         = CHIP_ENABLE;
         mem_re         = req_q.we ? 1'b0 : READ_ENABLE;
         mem_we         = req_q.we ? WRITE_ENABLE : 1'b0;
         mem_read_addr  = acc_addr;
         mem_write_addr = acc_addr;
         if (req_q.we) begin
            mem_write_data = (state == ST_ACC1) ? wdata_lo : wdata_hi;
            mem_write      = (state == ST_ACC1) ? lanes_lo : lanes_hi;
         end
      end

      if (state == ST_DONE) begin
         resp_valid = 1'b1;
         resp_err   = err_q;
         if (!err_q && !req_q.we) resp_rdata = ld_data;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a split-enabled instance against a
// small RAM model, plus a split-disabled instance with a fixed read word.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid, req_we, req_signed, sel;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        a_valid, b_valid;

   logic        a_ready, a_rvalid, a_err, a_ce, a_re, a_we;
   logic [31:0] a_rdata, a_raddr, a_waddr, a_wdata, a_mrdata;
   logic [3:0]  a_lanes;
   logic        b_ready, b_rvalid, b_err, b_ce, b_re, b_we;
   logic [31:0] b_rdata, b_raddr, b_waddr, b_wdata, b_mrdata;
   logic [3:0]  b_lanes;

   logic        s_ready, s_rvalid, s_err, s_ce, s_re, s_we;
   logic [31:0] s_rdata, s_raddr, s_waddr, s_wdata;
   logic [3:0]  s_lanes;

   logic [31:0] ram [0:1023];

   assign a_valid  = req_valid & ~sel;
   assign b_valid  = req_valid & sel;
   assign a_mrdata = ram[a_raddr[11:2]];
   assign b_mrdata = 32'h12345678;

   assign s_ready  = sel ? b_ready  : a_ready;
   assign s_rvalid = sel ? b_rvalid : a_rvalid;
   assign s_err    = sel ? b_err    : a_err;
   assign s_ce     = sel ? b_ce     : a_ce;
   assign s_re     = sel ? b_re     : a_re;
   assign s_we     = sel ? b_we     : a_we;
   assign s_rdata  = sel ? b_rdata  : a_rdata;
   assign s_raddr  = sel ? b_raddr  : a_raddr;
   assign s_waddr  = sel ? b_waddr  : a_waddr;
   assign s_wdata  = sel ? b_wdata  : a_wdata;
   assign s_lanes  = sel ? b_lanes  : a_lanes;

   mem_access_ctrl #(.SPLIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_rvalid),
      .resp_rdata(a_rdata), .resp_err(a_err), .mem_ce(a_ce), .mem_re(a_re),
      .mem_we(a_we), .mem_read_addr(a_raddr), .mem_read_data(a_mrdata),
      .mem_write_addr(a_waddr), .mem_write_data(a_wdata), .mem_write(a_lanes)
   );

   mem_access_ctrl #(.SPLIT_EN(1'b0)) dut_nosplit (
      .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_rvalid),
      .resp_rdata(b_rdata), .resp_err(b_err), .mem_ce(b_ce), .mem_re(b_re),
      .mem_we(b_we), .mem_read_addr(b_raddr), .mem_read_data(b_mrdata),
      .mem_write_addr(b_waddr), .mem_write_data(b_wdata), .mem_write(b_lanes)
   );

   // RAM model: byte-lane writes from the split-enabled instance
   always @(posedge clk) begin
      if (a_ce && a_we)
         for (int i = 0; i < 4; i++)
            if (a_lanes[i]) ram[a_waddr[11:2]][8*i +: 8] <= a_wdata[8*i +: 8];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   int          acc_n, resp_cyc;
   logic [31:0] acc_addr [2];
   logic [31:0] acc_data [2];
   logic [3:0]  acc_lanes [2];
   logic [1:0]  acc_rw [2];
   logic [31:0] r_data;
   logic        r_err, leak;

   // Issue one request, scramble the inputs after accept, and record every
   // RAM cycle and the response over a bounded window.
   task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
      int w;
      @(negedge clk);
      w = 0;
      while (!s_ready && w < 8) begin @(negedge clk); w++; end
      chk("ready_before_req", 32'(s_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_signed = ~sgn;
      req_addr = ~addr; req_wdata = ~wdata;
      acc_n = 0; resp_cyc = 0; leak = 1'b0; r_data = '0; r_err = 1'b0;
      for (int c = 1; c <= 6 && resp_cyc == 0; c++) begin
         @(negedge clk);
         if (s_ce) begin
            if (acc_n < 2) begin
               acc_addr[acc_n[0]]  = s_raddr;
               acc_data[acc_n[0]]  = s_wdata;
               acc_lanes[acc_n[0]] = s_lanes;
               acc_rw[acc_n[0]]    = {s_re, s_we};
               if (s_waddr !== s_raddr) leak = 1'b1;
            end
            acc_n++;
         end else if ((s_raddr | s_waddr | s_wdata) != 0 || s_lanes != 0 || s_re || s_we) begin
            leak = 1'b1;
         end
         if (s_rvalid) begin
            resp_cyc = c; r_data = s_rdata; r_err = s_err;
         end else if (s_rdata != 0 || s_err) begin
            leak = 1'b1;
         end
      end
   endtask

   task automatic chk_resp(input string tag, input int n_acc, input int cyc,
                           input logic [31:0] data, input logic err);
      chk({tag, ".acc_cnt"}, 32'(acc_n), 32'(n_acc));
      chk({tag, ".latency"}, 32'(resp_cyc), 32'(cyc));
      chk({tag, ".rdata"}, r_data, data);
      chk({tag, ".err"}, 32'(r_err), 32'(err));
      chk({tag, ".quiet_outputs"}, 32'(leak), 32'd0);
   endtask

   task automatic chk_acc(input string tag, input int i, input logic [31:0] addr, input logic [1:0] rw);
      chk({tag, ".addr"}, acc_addr[i[0]], addr);
      chk({tag, ".re_we"}, 32'(acc_rw[i[0]]), 32'(rw));
   endtask

   task automatic chk_wr(input string tag, input int i, input logic [3:0] lanes, input logic [31:0] data);
      chk({tag, ".lanes"}, 32'(acc_lanes[i[0]]), 32'(lanes));
      chk({tag, ".wdata"}, acc_data[i[0]], data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
      req_addr = 0; req_wdata = 0; sel = 0;
      repeat (2) @(negedge clk);
      chk("rst.ready", 32'(a_ready), 32'd1);
      chk("rst.ce", 32'(a_ce), 32'd0);
      chk("rst.resp_valid", 32'(a_rvalid), 32'd0);
      chk("rst.waddr", a_waddr, 32'd0);
      rst_n = 1'b1;

      // aligned word store and read-back
      run_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF);
      chk_resp("st_w", 1, 2, 32'h0, 1'b0);
      chk_acc("st_w", 0, 32'h100, 2'b01);
      chk_wr("st_w", 0, 4'b1111, 32'hDEADBEEF);
      run_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
      chk_resp("ld_w", 1, 2, 32'hDEADBEEF, 1'b0);
      chk_acc("ld_w", 0, 32'h100, 2'b10);

      // byte store into a preloaded word, then signed/unsigned loads
      run_req(1'b1, SZ_WORD, 1'b0, 32'h104, 32'h11223344);
      run_req(1'b1, SZ_BYTE, 1'b0, 32'h106, 32'hFFFFFF80);
      chk_resp("st_b", 1, 2, 32'h0, 1'b0);
      chk_wr("st_b", 0, 4'b0010, 32'h00008000);
      run_req(1'b0, SZ_BYTE, 1'b1, 32'h106, 32'h0);
      chk_resp("ld_bs", 1, 2, 32'hFFFFFF80, 1'b0);
      run_req(1'b0, SZ_BYTE, 1'b0, 32'h106, 32'h0);
      chk_resp("ld_bu", 1, 2, 32'h00000080, 1'b0);
      run_req(1'b0, SZ_HALF, 1'b1, 32'h106, 32'h0);
      chk_resp("ld_hs", 1, 2, 32'hFFFF8044, 1'b0);
      run_req(1'b0, SZ_HALF, 1'b1, 32'h104, 32'h0);
      chk_resp("ld_hs_pos", 1, 2, 32'h00001122, 1'b0);

      // split word load
      run_req(1'b1, SZ_WORD, 1'b0, 32'h200, 32'hAABBCCDD);
      run_req(1'b1, SZ_WORD, 1'b0, 32'h204, 32'h11223344);
      run_req(1'b0, SZ_WORD, 1'b0, 32'h201, 32'h0);
      chk_resp("ld_split", 2, 3, 32'hBBCCDD11, 1'b0);
      chk_acc("ld_split0", 0, 32'h200, 2'b10);
      chk_acc("ld_split1", 1, 32'h204, 2'b10);

      // split halfword store wrapping past the top of memory, then load back
      run_req(1'b1, SZ_HALF, 1'b0, 32'hFFFFFFFF, 32'h0000ABCD);
      chk_resp("st_wrap", 2, 3, 32'h0, 1'b0);
      chk_acc("st_wrap0", 0, 32'hFFFFFFFC, 2'b01);
      chk_wr("st_wrap0", 0, 4'b0001, 32'h000000AB);
      chk_acc("st_wrap1", 1, 32'h00000000, 2'b01);
      chk_wr("st_wrap1", 1, 4'b1000, 32'hCD000000);
      run_req(1'b0, SZ_HALF, 1'b1, 32'hFFFFFFFF, 32'h0);
      chk_resp("ld_wrap", 2, 3, 32'hFFFFABCD, 1'b0);

      // illegal size
      run_req(1'b0, SZ_ILL, 1'b0, 32'h100, 32'h0);
      chk_resp("ill_size", 0, 1, 32'h0, 1'b1);

      // split disabled: unaligned rejected, aligned unaffected
      sel = 1'b1;
      run_req(1'b0, SZ_WORD, 1'b0, 32'h202, 32'h0);
      chk_resp("nosplit_err", 0, 1, 32'h0, 1'b1);
      run_req(1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0);
      chk_resp("nosplit_h", 1, 2, 32'h00005678, 1'b0);
      run_req(1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0);
      chk_resp("nosplit_w", 1, 2, 32'h12345678, 1'b0);
      chk_acc("nosplit_w", 0, 32'h300, 2'b10);
      sel = 1'b0;

      // reset during the second cycle of a split store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
      req_addr = 32'h3FE; req_wdata = 32'h55667788;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      chk("midrst.in_acc1", 32'(a_ce), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst.ce", 32'(a_ce), 32'd0);
      chk("midrst.we", 32'(a_we), 32'd0);
      chk("midrst.lanes", 32'(a_lanes), 32'd0);
      chk("midrst.wdata", a_wdata, 32'd0);
      chk("midrst.resp_valid", 32'(a_rvalid), 32'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("midrst.no_resp", 32'(a_rvalid), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst.ready_after", 32'(a_ready), 32'd1);
      chk("midrst.no_resp_after", 32'(a_rvalid), 32'd0);
      run_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
      chk_resp("after_rst", 1, 2, 32'hDEADBEEF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
